fp_accum: RTL and testbench

- Downstream of the single-precision FP multiplier in the convolution datapath.
- Consumes a stream of multiplier products (sign, exponent, mantissa fields) and sums one kernel window into a single IEEE-754 single-precision result.
- Window end is marked by in_last. The result is handed to the activation/writeback stage over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_lzc.sv | 31 +++
 rtl/fp_accum.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fp_accum.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the floating-point accumulator.
//                Holds the default field widths, the exponent bias and
//                all-ones exponent constant, a packed fp32 view and the
//                accumulator state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_EXPONENT_WIDTH = 8;
    localparam int FP_MANTISSA_WIDTH = 23;
    localparam int EXP_BIAS          = 127;
    localparam logic [FP_EXPONENT_WIDTH-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic                         sign;
        logic [FP_EXPONENT_WIDTH-1:0] exp;
        logic [FP_MANTISSA_WIDTH-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        ACC   = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Combinational leading-zero counter used to normalize the
//                accumulator significand.
//  Ports       : i_value - vector to scan (MSB first)
//                o_count - number of leading zeros (WIDTH when all zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc
    import fp_pkg::*;
#(
    parameter int WIDTH   = FP_MANTISSA_WIDTH + 3,
    parameter int COUNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]   i_value,
    output logic [COUNT_W-1:0] o_count
);

    // Scan upward; the highest set bit is the last assignment and wins.
    always_comb begin
        o_count = COUNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_value[i]) begin
                o_count = COUNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_accum.sv
`default_nettype none
// ============================================================================
//  Module      : fp_accum
//  Description : Sums a window of single-precision products into one IEEE-754
//                result. One term per 4 cycles (ACC, ALIGN, ADD, NORM);
//                truncating rounding, denormals flushed, overflow saturates
//                to a signed infinity that is sticky for the window.
//  Ports       : clk, rst_n (synchronous, active low)
//                in_valid/in_ready, in_sign/in_exp/in_man, in_last
//                out_valid/out_ready, out_data {sign,exp,man}, out_count
//  Options     : FP_ACCUM_RELU_EN - when defined, a negative nonzero sum is
//                emitted as +0 (accumulator contents unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_accum
    import fp_pkg::*;
#(
    parameter int EXPONENT_WIDTH = FP_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     in_sign,
    input  logic [EXPONENT_WIDTH-1:0]                in_exp,
    input  logic [MANTISSA_WIDTH-1:0]                in_man,
    input  logic                                     in_last,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   out_data,
    output logic [COUNT_WIDTH-1:0]                   out_count
);

    // Significand = hidden bit + mantissa + 2 guard bits
    localparam int c_sig_w  = MANTISSA_WIDTH + 3;
    localparam int c_lz_w   = $clog2(c_sig_w + 1);
    localparam int c_data_w = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;
    // Two extra bits: one for carry headroom, one as a sign for underflow
    localparam int c_ext_w  = EXPONENT_WIDTH + 2;
    localparam logic [EXPONENT_WIDTH-1:0] c_exp_max   = '1;
    localparam logic [EXPONENT_WIDTH-1:0] c_shift_lim = EXPONENT_WIDTH'(c_sig_w);

    acc_state_t r_state;
    acc_state_t w_state_next;

    logic [c_data_w-1:0]       r_acc;
    logic [COUNT_WIDTH-1:0]    r_count;
    logic                      r_t_sign;
    logic [EXPONENT_WIDTH-1:0] r_t_exp;
    logic [MANTISSA_WIDTH-1:0] r_t_man;
    logic                      r_last;
    logic                      r_a_sign;
    logic                      r_b_sign;
    logic [c_sig_w-1:0]        r_a_sig;
    logic [c_sig_w-1:0]        r_b_sig;
    logic [EXPONENT_WIDTH-1:0] r_exp;
    logic [c_sig_w:0]          r_sum;
    logic                      r_sum_sign;

    // ------------------------------------------------------------------
    // Accumulator field views
    // ------------------------------------------------------------------
    logic                      w_acc_sign;
    logic [EXPONENT_WIDTH-1:0] w_acc_exp;
    logic [MANTISSA_WIDTH-1:0] w_acc_man;
    logic                      w_acc_inf;

    assign w_acc_sign = r_acc[c_data_w-1];
    assign w_acc_exp  = r_acc[c_data_w-2 -: EXPONENT_WIDTH];
    assign w_acc_man  = r_acc[MANTISSA_WIDTH-1:0];
    assign w_acc_inf  = (w_acc_exp == c_exp_max);

    // ------------------------------------------------------------------
    // ALIGN: exp==0 operands become zero; the smaller one is shifted right
    // ------------------------------------------------------------------
    logic [EXPONENT_WIDTH-1:0] w_acc_e, w_t_e, w_diff, w_big_exp;
    logic [c_sig_w-1:0]        w_acc_sig, w_t_sig, w_a_al, w_b_al;

    always_comb begin
        w_acc_e   = (w_acc_exp == '0) ? '0 : w_acc_exp;
        w_t_e     = (r_t_exp == '0)   ? '0 : r_t_exp;
        w_acc_sig = (w_acc_exp == '0) ? '0 : {1'b1, w_acc_man, 2'b00};
        w_t_sig   = (r_t_exp == '0)   ? '0 : {1'b1, r_t_man, 2'b00};
        w_a_al    = w_acc_sig;
        w_b_al    = w_t_sig;
        w_big_exp = w_acc_e;
        w_diff    = '0;
        if (w_acc_e >= w_t_e) begin
            w_diff    = w_acc_e - w_t_e;
            w_big_exp = w_acc_e;
            w_b_al    = (w_diff >= c_shift_lim) ? '0 : (w_t_sig >> w_diff);
        end else begin
            w_diff    = w_t_e - w_acc_e;
            w_big_exp = w_t_e;
            w_a_al    = (w_diff >= c_shift_lim) ? '0 : (w_acc_sig >> w_diff);
        end
    end

    // ------------------------------------------------------------------
    // ADD: sign-magnitude add; exact cancellation yields +0
    // ------------------------------------------------------------------
    logic [c_sig_w:0] w_sum;
    logic             w_sum_sign;

    always_comb begin
        w_sum      = '0;
        w_sum_sign = 1'b0;
        if (r_a_sign == r_b_sign) begin
            w_sum      = {1'b0, r_a_sig} + {1'b0, r_b_sig};
            w_sum_sign = r_a_sign;
        end else if (r_a_sig > r_b_sig) begin
            w_sum      = {1'b0, r_a_sig - r_b_sig};
            w_sum_sign = r_a_sign;
        end else if (r_b_sig > r_a_sig) begin
            w_sum      = {1'b0, r_b_sig - r_a_sig};
            w_sum_sign = r_b_sign;
        end
    end

    // ------------------------------------------------------------------
    // NORM: renormalize, detect underflow/overflow, truncate
    // ------------------------------------------------------------------
    logic [c_lz_w-1:0]   w_lz;
    logic [c_sig_w-1:0]  w_norm_sig;
    logic [c_ext_w-1:0]  w_norm_exp;
    logic [c_data_w-1:0] w_norm_result;
    logic                w_unused;

    fp_lzc #(
        .WIDTH   (c_sig_w),
        .COUNT_W (c_lz_w)
    ) u_lzc (
        .i_value (r_sum[c_sig_w-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        if (r_sum[c_sig_w]) begin
            w_norm_sig = r_sum[c_sig_w:1];
            w_norm_exp = c_ext_w'(r_exp) + c_ext_w'(1);
        end else begin
            w_norm_sig = r_sum[c_sig_w-1:0] << w_lz;
            w_norm_exp = c_ext_w'(r_exp) - c_ext_w'(w_lz);
        end

        if ((r_sum == '0) || w_norm_exp[c_ext_w-1] || (w_norm_exp == '0)) begin
            w_norm_result = '0;
        end else if (w_norm_exp >= c_ext_w'(c_exp_max)) begin
            w_norm_result = {r_sum_sign, c_exp_max, {MANTISSA_WIDTH{1'b0}}};
        end else begin
            w_norm_result = {r_sum_sign, w_norm_exp[EXPONENT_WIDTH-1:0],
                             w_norm_sig[c_sig_w-2:2]};
        end
    end

    // Hidden bit and guard bits are dropped by truncation
    assign w_unused = &{1'b0, w_norm_sig[c_sig_w-1], w_norm_sig[1:0]};

    // ------------------------------------------------------------------
    // Output view
    // ------------------------------------------------------------------
    logic [c_data_w-1:0] w_out_view;

`ifdef FP_ACCUM_RELU_EN
    assign w_out_view = (w_acc_sign && (r_acc[c_data_w-2:0] != '0)) ? '0 : r_acc;
`else
    assign w_out_view = r_acc;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_count    = '0;
        case (r_state)
            ACC: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_state_next = ALIGN;
                end
            end
            ALIGN: w_state_next = ADD;
            ADD:   w_state_next = NORM;
            NORM:  w_state_next = r_last ? DONE : ACC;
            DONE: begin
                out_valid = rst_n;
                out_data  = w_out_view;
                out_count = r_count;
                if (out_ready) begin
                    w_state_next = ACC;
                end
            end
            default: w_state_next = ACC;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_t_sign   <= 1'b0;
            r_t_exp    <= '0;
            r_t_man    <= '0;
            r_last     <= 1'b0;
            r_a_sign   <= 1'b0;
            r_b_sign   <= 1'b0;
            r_a_sig    <= '0;
            r_b_sig    <= '0;
            r_exp      <= '0;
            r_sum      <= '0;
            r_sum_sign <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (in_valid) begin
                        r_t_sign <= in_sign;
                        r_t_exp  <= in_exp;
                        r_t_man  <= in_man;
                        r_last   <= in_last;
                        r_count  <= r_count + 1'b1;
                    end
                end
                ALIGN: begin
                    r_a_sign <= w_acc_sign;
                    r_b_sign <= r_t_sign;
                    r_a_sig  <= w_a_al;
                    r_b_sig  <= w_b_al;
                    r_exp    <= w_big_exp;
                end
                ADD: begin
                    r_sum      <= w_sum;
                    r_sum_sign <= w_sum_sign;
                end
                NORM: begin
                    // Saturated infinity is held until the window is emitted
                    if (!w_acc_inf) begin
                        r_acc <= w_norm_result;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_accum
//  Description : Directed self-checking bench for fp_accum. Expected sums are
//                hand-computed IEEE-754 single-precision constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_man;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;

    int errors = 0;
    int checks = 0;

    fp_accum #(
        .EXPONENT_WIDTH (8),
        .MANTISSA_WIDTH (23),
        .COUNT_WIDTH    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] w, input logic last);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_sign  = w[31];
        in_exp   = w[30:23];
        in_man   = w[22:0];
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_window(input string tag, input logic [31:0] data, input logic [15:0] cnt);
        wait_out();
        chk({tag, "_data"}, out_data, data);
        chk({tag, "_count"}, {16'd0, out_count}, {16'd0, cnt});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_count", {16'd0, out_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // +15 + +24 = +39, with exact output latency
        send(32'h41700000, 1'b0);
        send(32'h41C00000, 1'b1);
        chk("lat_align", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_add", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_norm", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_done", {31'd0, out_valid}, 32'd1);
        expect_window("sum39", 32'h421C0000, 16'd2);

        // Exact cancellation
        send(32'hC1C80000, 1'b0);
        send(32'h41C80000, 1'b1);
        expect_window("cancel", 32'h00000000, 16'd2);

        // -35 + 15 = -20
        send(32'hC20C0000, 1'b0);
        send(32'h41700000, 1'b1);
`ifdef FP_ACCUM_RELU_EN
        expect_window("neg20", 32'h00000000, 16'd2);
`else
        expect_window("neg20", 32'hC1A00000, 16'd2);
`endif

        // Overflow saturates to +inf
        send(32'h7F000000, 1'b0);
        send(32'h7F000000, 1'b1);
        expect_window("ovf", 32'h7F800000, 16'd2);

        // Single-term pass-through
        send(32'h3E800000, 1'b1);
        expect_window("single", 32'h3E800000, 16'd1);

        // Denormal term flushed to zero
        send(32'h00400000, 1'b1);
        expect_window("denorm", 32'h00000000, 16'd1);
        send(32'h3F800000, 1'b0);
        send(32'h00400000, 1'b1);
        expect_window("denorm_add", 32'h3F800000, 16'd2);

        // Shift of 26 drops the smaller term entirely
        send(32'h4C800000, 1'b0);
        send(32'h3F800000, 1'b1);
        expect_window("bigshift", 32'h4C800000, 16'd2);

        // Backpressure: output held, input ignored
        send(32'h40000000, 1'b0);
        send(32'h40600000, 1'b1);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_exp   = 8'h80;
            in_man   = 23'h0;
            in_last  = 1'b1;
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", out_data, 32'h40B00000);
            chk("bp_count", {16'd0, out_count}, 32'd2);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h3F800000, 1'b1);
        expect_window("after_bp", 32'h3F800000, 16'd1);

        // Reset during ADD of a 3-term window
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send(32'h40000000, 1'b0);
        send(32'h40600000, 1'b1);
        expect_window("after_rst", 32'h40B00000, 16'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
